// File: rtl/spi_frame_arbiter.sv
// Round-robin arbiter that shares one byte-level SPI master between N_REQ frame requesters,
// framing each transfer with that requester's own active-low select/LOAD line.
`timescale 1ns/1ps

module spi_frame_arbiter #(
    parameter int N_REQ        = 2,
    parameter int FRAME_BYTES  = 2,
    parameter int SETUP_CYCLES = 4,
    parameter int HOLD_CYCLES  = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_REQ-1:0]               req_valid,
    input  logic [N_REQ*FRAME_BYTES*8-1:0] req_data,
    output logic [N_REQ-1:0]               req_ready,
    output logic [N_REQ-1:0]               req_done,
    output logic [N_REQ-1:0]               sel_n,
    output logic                           spi_start,
    output logic [7:0]                     spi_data,
    input  logic                           spi_busy,
    output logic                           busy
);

    localparam int FW      = FRAME_BYTES * 8;
    localparam int CNT_MAX = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int BI_W    = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam int PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [BI_W-1:0]  BYTE_LAST  = BI_W'(FRAME_BYTES - 1);
    localparam logic [PTR_W-1:0] PTR_RESET  = PTR_W'(N_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_START,
        S_WAIT,
        S_RELEASE,
        S_HOLD
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   grant_q, grant_d;
    logic [FW-1:0]      shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BI_W-1:0]    byte_idx_q, byte_idx_d;
    logic [N_REQ-1:0]   sel_n_q, sel_n_d;
    logic [N_REQ-1:0]   req_ready_q, req_ready_d;
    logic [N_REQ-1:0]   req_done_q, req_done_d;
    logic               spi_start_q, spi_start_d;
    logic [7:0]         spi_data_q, spi_data_d;
    logic               busy_q, busy_d;

    logic               any_valid;
    logic [PTR_W-1:0]   pick;
    logic [PTR_W-1:0]   scan_idx;

    // Scan from the farthest candidate back to ptr+1 so the nearest valid index wins.
    always_comb begin
        any_valid = |req_valid;
        pick      = '0;
        scan_idx  = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            scan_idx = PTR_W'((int'(ptr_q) + k) % N_REQ);
            if (req_valid[scan_idx]) begin
                pick = scan_idx;
            end
        end
    end

    // NOTE: every signal gets its hold value before the case so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        byte_idx_d  = byte_idx_q;
        sel_n_d     = sel_n_q;
        spi_start_d = 1'b0;
        spi_data_d  = spi_data_q;
        req_ready_d = '0;
        req_done_d  = '0;

        case (state_q)
            S_IDLE: begin
                if (any_valid) begin
                    grant_d           = pick;
                    ptr_d             = pick;
                    shift_d           = req_data[int'(pick) * FW +: FW];
                    req_ready_d[pick] = 1'b1;
                    sel_n_d           = '1;
                    sel_n_d[pick]     = 1'b0;
                    cnt_d             = '0;
                    byte_idx_d        = '0;
                    state_d           = S_SETUP;
                end
            end
            S_SETUP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SETUP_LAST) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                spi_data_d  = shift_q[FW-1 -: 8];
                spi_start_d = 1'b1;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                // The master raises busy in the same cycle it sees start, so low here means byte done.
                if (!spi_busy) begin
                    shift_d = shift_q << 8;
                    if (byte_idx_q == BYTE_LAST) begin
                        state_d = S_RELEASE;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                        state_d    = S_START;
                    end
                end
            end
            S_RELEASE: begin
                sel_n_d = '1;
                cnt_d   = '0;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == HOLD_LAST) begin
                    req_done_d[grant_q] = 1'b1;
                    state_d             = S_IDLE;
                end
            end
            default: begin
                sel_n_d = '1;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= PTR_RESET;
            grant_q     <= '0;
            shift_q     <= '0;
            cnt_q       <= '0;
            byte_idx_q  <= '0;
            sel_n_q     <= '1;
            req_ready_q <= '0;
            req_done_q  <= '0;
            spi_start_q <= 1'b0;
            spi_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            byte_idx_q  <= byte_idx_d;
            sel_n_q     <= sel_n_d;
            req_ready_q <= req_ready_d;
            req_done_q  <= req_done_d;
            spi_start_q <= spi_start_d;
            spi_data_q  <= spi_data_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready = req_ready_q;
    assign req_done  = req_done_q;
    assign sel_n     = sel_n_q;
    assign spi_start = spi_start_q;
    assign spi_data  = spi_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_spi_frame_arbiter.sv
// Directed bench for spi_frame_arbiter: behavioural 20-cycle SPI master plus one
// shift-register slave per select line that latches its word on the select rising edge.
`timescale 1ns/1ps

module tb_spi_frame_arbiter;

    localparam int N_REQ  = 2;
    localparam int FB     = 2;
    localparam int SETUP  = 4;
    localparam int HOLD   = 16;
    localparam int BYTE_T = 20;
    // Ready seen in first SETUP cycle; each byte is START + BYTE_T busy cycles + 1 done cycle.
    localparam int FRAME_T = SETUP + FB * (2 + BYTE_T) + 1 + HOLD;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [31:0] req_data;
    logic [1:0]  req_ready;
    logic [1:0]  req_done;
    logic [1:0]  sel_n;
    logic        spi_start;
    logic [7:0]  spi_data;
    logic        spi_busy;
    logic        busy;

    int checks = 0;
    int errors = 0;

    spi_frame_arbiter #(
        .N_REQ       (N_REQ),
        .FRAME_BYTES (FB),
        .SETUP_CYCLES(SETUP),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .req_done (req_done),
        .sel_n    (sel_n),
        .spi_start(spi_start),
        .spi_data (spi_data),
        .spi_busy (spi_busy),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Behavioural SPI master and slaves
    int unsigned mcnt = 0;
    int          byte_n = 0;
    logic [7:0]  byte_log [64];
    logic [31:0] slave_sr [2];

    assign spi_busy = spi_start || (mcnt != 0);

    always @(posedge clk) begin
        if (rst) begin
            mcnt <= 0;
        end else if (spi_start && mcnt == 0) begin
            mcnt                <= BYTE_T - 1;
            byte_log[byte_n % 64] <= spi_data;
            byte_n              <= byte_n + 1;
            for (int i = 0; i < 2; i++) begin
                if (!sel_n[i]) slave_sr[i] <= {slave_sr[i][23:0], spi_data};
            end
        end else if (mcnt != 0) begin
            mcnt <= mcnt - 1;
        end
    end

    // Monitors sampled on the falling edge
    logic [1:0]  prev_sel   = 2'b11;
    logic        prev_start = 1'b0;
    logic        prev_busy  = 1'b0;
    logic [7:0]  prev_data  = 8'h00;
    logic [15:0] slave_word [2];
    int          latch_cnt [2] = '{0, 0};
    int          both_low = 0, wide_start = 0, data_chg = 0;
    int          grant_log [64];
    int          grant_n = 0, done_n = 0;
    int          cyc = 0, fall_cyc = 0, last_gap = -1;
    logic        gap_pending = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (sel_n == 2'b00) both_low <= both_low + 1;
        if (spi_start && prev_start) wide_start <= wide_start + 1;
        if (spi_busy && prev_busy && spi_data != prev_data) data_chg <= data_chg + 1;
        if (req_ready != 2'b00) begin
            grant_log[grant_n % 64] <= req_ready[1] ? 1 : 0;
            grant_n                 <= grant_n + 1;
        end
        if (req_done != 2'b00) done_n <= done_n + 1;
        if (prev_sel == 2'b11 && sel_n != 2'b11) begin
            fall_cyc    <= cyc;
            gap_pending <= 1'b1;
        end else if (gap_pending && spi_start) begin
            last_gap    <= cyc - fall_cyc;
            gap_pending <= 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            if (!prev_sel[i] && sel_n[i]) begin
                slave_word[i] <= slave_sr[i][15:0];
                latch_cnt[i]  <= latch_cnt[i] + 1;
            end
        end
        prev_sel   <= sel_n;
        prev_start <= spi_start;
        prev_busy  <= spi_busy;
        prev_data  <= spi_data;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits up to limit falling edges for a ready (is_done=0) or done (is_done=1) pulse on idx.
    task automatic wait_pulse(input string tag, input bit is_done, input int idx,
                              input int limit, output int n);
        logic hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < limit) begin
            @(negedge clk);
            n++;
            hit = is_done ? req_done[idx] : req_ready[idx];
        end
        check({tag, "_seen"}, 64'(hit), 64'd1);
    endtask

    initial begin
        int n, b0, l0, d0, idx;

        rst       = 1'b1;
        req_valid = 2'b00;
        req_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_sel_n", 64'(sel_n), 64'h3);
        check("rst_start", 64'(spi_start), 64'h0);
        check("rst_data", 64'(spi_data), 64'h0);
        check("rst_ready", 64'(req_ready), 64'h0);
        check("rst_done", 64'(req_done), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        rst = 1'b0;
        @(negedge clk);

        // 1: single frame from requester 0
        b0 = byte_n;
        l0 = latch_cnt[0];
        req_valid       = 2'b01;
        req_data[15:0]  = 16'h0A07;
        @(negedge clk);
        check("t1_ready", 64'(req_ready), 64'h1);
        check("t1_sel_low", 64'(sel_n), 64'h2);
        req_valid = 2'b00;
        wait_pulse("t1_done", 1'b1, 0, 200, n);
        check("t1_latency", 64'(n), 64'(FRAME_T));
        #1;
        check("t1_byte0", 64'(byte_log[b0 % 64]), 64'h0A);
        check("t1_byte1", 64'(byte_log[(b0 + 1) % 64]), 64'h07);
        check("t1_slave0", 64'(slave_word[0]), 64'h0A07);
        check("t1_one_latch", 64'(latch_cnt[0]), 64'(l0 + 1));
        // The START cycle registers the pulse, so it follows the setup count by one cycle.
        check("t1_setup_gap", 64'(last_gap), 64'(SETUP + 1));
        check("t1_sel_idle", 64'(sel_n), 64'h3);
        check("t1_busy_idle", 64'(busy), 64'h0);

        // 2: simultaneous requests straight from reset
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        req_data  = {16'h0304, 16'h0102};
        req_valid = 2'b11;
        wait_pulse("t2_ready0", 1'b0, 0, 5, n);
        check("t2_first_grant", 64'(req_ready), 64'h1);
        req_valid = 2'b10;
        wait_pulse("t2_ready1", 1'b0, 1, 200, n);
        check("t2_back_to_back", 64'(n), 64'(FRAME_T + 1));
        req_valid = 2'b00;
        wait_pulse("t2_done1", 1'b1, 1, 200, n);
        #1;
        check("t2_slave0", 64'(slave_word[0]), 64'h0102);
        check("t2_slave1", 64'(slave_word[1]), 64'h0304);

        // 3: both held valid for 8 frames, data refreshed after each ready
        req_data  = {16'h2000, 16'h1000};
        req_valid = 2'b11;
        for (int k = 0; k < 8; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (req_ready == 2'b00 && n < 200);
            check("t3_ready_seen", 64'(req_ready != 2'b00), 64'd1);
            idx = req_ready[1] ? 1 : 0;
            check($sformatf("t3_grant%0d", k), 64'(idx), 64'(k % 2));
            if (k < 7) req_data[idx*16 +: 16] = 16'hC000 + 16'(k * 16 + idx);
            else       req_valid = 2'b00;
        end
        wait_pulse("t3_done", 1'b1, 1, 200, n);
        #1;
        check("t3_slave0", 64'(slave_word[0]), 64'hC040);
        check("t3_slave1", 64'(slave_word[1]), 64'hC051);
        check("t3_start_width", 64'(wide_start), 64'h0);
        check("t3_data_stable", 64'(data_chg), 64'h0);
        check("t3_one_select", 64'(both_low), 64'h0);

        // 5: reset during the second byte of a requester-1 frame
        req_data[31:16] = 16'hBEEF;
        req_valid       = 2'b10;
        wait_pulse("t5_ready1", 1'b0, 1, 5, n);
        req_valid = 2'b00;
        b0 = byte_n;
        n  = 0;
        while (byte_n < b0 + 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t5_second_byte", 64'(byte_n >= b0 + 2), 64'd1);
        d0  = done_n;
        rst = 1'b1;
        @(negedge clk);
        check("t5_sel_n", 64'(sel_n), 64'h3);
        check("t5_start", 64'(spi_start), 64'h0);
        check("t5_busy", 64'(busy), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        check("t5_no_done", 64'(done_n), 64'(d0));
        req_data[31:16] = 16'h5A3C;
        req_valid       = 2'b10;
        wait_pulse("t5_ready_again", 1'b0, 1, 5, n);
        check("t5_grant1", 64'(req_ready), 64'h2);
        req_valid = 2'b00;
        wait_pulse("t5_done1", 1'b1, 1, 200, n);
        #1;
        check("t5_slave1", 64'(slave_word[1]), 64'h5A3C);

        // 6: valid[1] rises mid-frame while valid[0] stays high with new data
        req_data  = {16'h9ABC, 16'h1357};
        req_valid = 2'b01;
        wait_pulse("t6_ready0", 1'b0, 0, 5, n);
        req_data[15:0] = 16'h2468;
        repeat (10) @(negedge clk);
        req_valid = 2'b11;
        wait_pulse("t6_done0", 1'b1, 0, 200, n);
        wait_pulse("t6_ready1", 1'b0, 1, 5, n);
        check("t6_ready1_gap", 64'(n), 64'd1);
        req_valid = 2'b01;
        wait_pulse("t6_ready0_again", 1'b0, 0, 200, n);
        check("t6_resend_gap", 64'(n), 64'(FRAME_T + 1));
        req_valid = 2'b00;
        wait_pulse("t6_done0_again", 1'b1, 0, 200, n);
        #1;
        check("t6_order_a", 64'(grant_log[(grant_n - 3) % 64]), 64'd0);
        check("t6_order_b", 64'(grant_log[(grant_n - 2) % 64]), 64'd1);
        check("t6_order_c", 64'(grant_log[(grant_n - 1) % 64]), 64'd0);
        check("t6_slave0", 64'(slave_word[0]), 64'h2468);
        check("t6_slave1", 64'(slave_word[1]), 64'h9ABC);
        check("t6_one_select", 64'(both_low), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
